// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports: clk, resetn; dividend/divisor stream in; {quotient,remainder} out with one-cycle valid.
module iter_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic             rdy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic             q_neg;
  logic             r_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             take;
  logic [WIDTH:0]   part;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             last;

  assign s_axis_dividend_tready = rdy;
  assign s_axis_divisor_tready  = rdy;

  assign a_neg = SIGNED & s_axis_dividend_tdata[WIDTH-1];
  assign b_neg = SIGNED & s_axis_divisor_tdata[WIDTH-1];
  assign a_mag = a_neg ? -s_axis_dividend_tdata
                       : s_axis_dividend_tdata;
  assign b_mag = b_neg ? -s_axis_divisor_tdata
                       : s_axis_divisor_tdata;

  assign take = rdy & s_axis_dividend_tvalid
                    & s_axis_divisor_tvalid;

  // dvd shifts the dividend out of its MSB while the
  // quotient bits shift into its LSB.
  assign part   = {rem, dvd[WIDTH-1]};
  assign diff   = part - {1'b0, dsr};
  assign qbit   = ~diff[WIDTH];
  assign rem_nx = qbit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
  assign quo_nx = {dvd[WIDTH-2:0], qbit};

  assign q_out = q_neg ? -quo_nx : quo_nx;
  assign r_out = r_neg ? -rem_nx : rem_nx;
  assign last  = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      rdy                <= 1'b0;
      cnt                <= '0;
      dvd                <= '0;
      dsr                <= '0;
      rem                <= '0;
      q_neg              <= 1'b0;
      r_neg              <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          m_axis_dout_tvalid <= 1'b0;
          if (take) begin
            dvd   <= a_mag;
            dsr   <= b_mag;
            rem   <= '0;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            cnt   <= '0;
            rdy   <= 1'b0;
            state <= CALC;
          end else begin
            rdy <= 1'b1;
          end
        end
        CALC: begin
          dvd <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            m_axis_dout_tdata  <= {q_out, r_out};
            m_axis_dout_tvalid <= 1'b1;
            state              <= DONE;
          end
        end
        DONE: begin
          m_axis_dout_tvalid <= 1'b0;
          rdy                <= 1'b1;
          state              <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: signed and unsigned instances on shared stimulus.
// Cycle model from arithmetic results plus literal result/latency checks.
module tb_iter_divider;

  localparam int W = 32;

  logic         clk;
  logic         resetn = 1'b0;
  logic [W-1:0] a_d = '0;
  logic [W-1:0] b_d = '0;
  logic         av = 1'b0;
  logic         bv = 1'b0;

  logic         ra_u, rb_u, vld_u;
  logic         ra_s, rb_s, vld_s;
  logic [2*W-1:0] dout_u, dout_s;

  int checks = 0;
  int passes = 0;

  iter_divider #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_dividend_tdata  (a_d),
    .s_axis_dividend_tvalid (av),
    .s_axis_dividend_tready (ra_u),
    .s_axis_divisor_tdata   (b_d),
    .s_axis_divisor_tvalid  (bv),
    .s_axis_divisor_tready  (rb_u),
    .m_axis_dout_tdata      (dout_u),
    .m_axis_dout_tvalid     (vld_u)
  );

  iter_divider #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk                    (clk),
    .resetn                 (resetn),
    .s_axis_dividend_tdata  (a_d),
    .s_axis_dividend_tvalid (av),
    .s_axis_dividend_tready (ra_s),
    .s_axis_divisor_tdata   (b_d),
    .s_axis_divisor_tvalid  (bv),
    .s_axis_divisor_tready  (rb_s),
    .m_axis_dout_tdata      (dout_s),
    .m_axis_dout_tvalid     (vld_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] exp_u(input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 0) return {32'hFFFF_FFFF, a};
    q = a / b;
    r = a % b;
    return {q, r};
  endfunction

  function automatic logic [63:0] exp_s(input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 0) return {(a[31] ? 32'h1 : 32'hFFFF_FFFF), a};
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    q  = sa / sb;
    r  = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // Cycle model: t counts edges since the accepting edge.
  logic        m_ready = 1'b0;
  logic        m_valid = 1'b0;
  logic [63:0] m_du = '0;
  logic [63:0] m_ds = '0;
  logic [63:0] p_u = '0;
  logic [63:0] p_s = '0;
  logic        busy = 1'b0;
  int          t = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_du    = '0;
      m_ds    = '0;
      busy    = 1'b0;
      t       = 0;
    end else if (!busy) begin
      if (m_ready && av && bv) begin
        busy    = 1'b1;
        t       = 0;
        m_ready = 1'b0;
        p_u     = exp_u(a_d, b_d);
        p_s     = exp_s(a_d, b_d);
      end else begin
        m_ready = 1'b1;
      end
    end else begin
      t++;
      if (t == W) begin
        m_valid = 1'b1;
        m_du    = p_u;
        m_ds    = p_s;
      end else if (t == W + 1) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
        busy    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_ready_a_u", {63'd0, ra_u}, {63'd0, m_ready});
    chk("cyc_ready_b_u", {63'd0, rb_u}, {63'd0, m_ready});
    chk("cyc_ready_a_s", {63'd0, ra_s}, {63'd0, m_ready});
    chk("cyc_ready_b_s", {63'd0, rb_s}, {63'd0, m_ready});
    chk("cyc_valid_u", {63'd0, vld_u}, {63'd0, m_valid});
    chk("cyc_valid_s", {63'd0, vld_s}, {63'd0, m_valid});
    chk("cyc_data_u", dout_u, m_du);
    chk("cyc_data_s", dout_s, m_ds);
  end

  task automatic wait_pulse(input string name,
                            input int k0,
                            input int lat,
                            input logic [63:0] eu,
                            input logic [63:0] es);
    int k;
    k = k0;
    while (!vld_u && k < k0 + 80) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_latency"}, 64'(k), 64'(lat));
    chk({name, "_u"}, dout_u, eu);
    chk({name, "_s"}, dout_s, es);
  endtask

  task automatic run_op(input string name,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] eu,
                        input logic [63:0] es);
    @(negedge clk);
    a_d = a;
    b_d = b;
    av  = 1'b1;
    bv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    av = 1'b0;
    bv = 1'b0;
    wait_pulse(name, 0, W, eu, es);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [63:0] held;
    int k;
    int pulses;

    chk("pin_u_100_7", exp_u(32'd100, 32'd7), {32'hE, 32'h2});
    chk("pin_s_m7_2", exp_s(32'hFFFF_FFF9, 32'd2),
        {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    chk("pin_s_ovf", exp_s(32'h8000_0000, 32'hFFFF_FFFF),
        {32'h8000_0000, 32'h0});
    chk("pin_s_m5_0", exp_s(32'hFFFF_FFFB, 32'd0),
        {32'h1, 32'hFFFF_FFFB});

    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, ra_u}, 64'd0);
    chk("rst_valid", {63'd0, vld_s}, 64'd0);
    chk("rst_data", dout_s, 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, ra_s}, 64'd1);

    run_op("div_100_7", 32'd100, 32'd7,
           {32'hE, 32'h2}, {32'hE, 32'h2});
    run_op("m7_div_2", 32'hFFFF_FFF9, 32'd2,
           {32'h7FFF_FFFC, 32'h1}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run_op("7_div_m2", 32'd7, 32'hFFFF_FFFE,
           {32'h0, 32'h7}, {32'hFFFF_FFFD, 32'h1});
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF,
           {32'h0, 32'h8000_0000}, {32'h8000_0000, 32'h0});
    run_op("5_div_0", 32'd5, 32'd0,
           {32'hFFFF_FFFF, 32'h5}, {32'hFFFF_FFFF, 32'h5});
    run_op("m5_div_0", 32'hFFFF_FFFB, 32'd0,
           {32'hFFFF_FFFF, 32'hFFFF_FFFB}, {32'h1, 32'hFFFF_FFFB});

    // Only the dividend valid: nothing may start.
    @(negedge clk);
    a_d = 32'd50;
    av  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("partial_ready", {63'd0, ra_u}, 64'd1);
      chk("partial_valid", {63'd0, vld_u}, 64'd0);
    end
    run_op("partial_50_5", 32'd50, 32'd5,
           {32'hA, 32'h0}, {32'hA, 32'h0});

    // Asynchronous reset ten cycles into the computation.
    @(negedge clk);
    a_d = 32'd123;
    b_d = 32'd4;
    av  = 1'b1;
    bv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    av = 1'b0;
    bv = 1'b0;
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_ready_u", {63'd0, ra_u}, 64'd0);
    chk("abort_ready_s", {63'd0, rb_s}, 64'd0);
    chk("abort_valid_u", {63'd0, vld_u}, 64'd0);
    chk("abort_valid_s", {63'd0, vld_s}, 64'd0);
    chk("abort_data_u", dout_u, 64'd0);
    chk("abort_data_s", dout_s, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (vld_u || vld_s) pulses++;
    end
    chk("abort_no_pulse", 64'(pulses), 64'd0);
    run_op("after_rst_9_3", 32'd9, 32'd3,
           {32'h3, 32'h0}, {32'h3, 32'h0});

    // Back-to-back with valids held and operands changed mid-flight.
    @(negedge clk);
    a_d = 32'd1000;
    b_d = 32'd10;
    av  = 1'b1;
    bv  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_d = 32'hFFFF_FFFF;
    b_d = 32'h10;
    wait_pulse("b2b_first", 0, W,
               {32'h64, 32'h0}, {32'h64, 32'h0});
    held = dout_u;
    k = W;
    while (k < W + 80) begin
      @(negedge clk);
      k++;
      if (k == W + 2) begin
        av = 1'b0;
        bv = 1'b0;
      end
      if (vld_u) break;
      chk("b2b_hold", dout_u, held);
    end
    chk("b2b_second_latency", 64'(k), 64'(2 * W + 2));
    chk("b2b_second_u", dout_u, {32'h0FFF_FFFF, 32'hF});
    chk("b2b_second_s", dout_s, {32'h0, 32'hFFFF_FFFF});
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
